// File: rtl/adc_frame_reader.sv
// adc_frame_reader
// ----------------
// Drains one captured frame from the ADC capture FIFO after the capture stage
// reports end-of-capture. The frame goes out on a valid/ready byte stream in
// this order:
//   1. the header byte;
//   2. two bytes per sample, high byte first, zero padded;
//   3. an XOR checksum of the sample bytes.
// A one-cycle re-arm pulse then lets the capture stage start the next
// acquisition.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   Cap_end     capture complete (level); a rising edge starts a frame
//   Fifo_empty  capture FIFO empty flag
//   Fifo_q      FIFO read data, valid the cycle after Fifo_rdreq
//   Fifo_rdreq  FIFO read strobe (single-cycle pulses)
//   Tx_data     stream byte (registered)
//   Tx_valid    stream byte valid (registered)
//   Tx_ready    sink accepts the byte when Tx_valid && Tx_ready
//   Frame_busy  high from the header byte through the checksum byte
//   Frame_done  one-cycle pulse after the checksum is accepted
//   Cap_rearm   one-cycle pulse, coincident with Frame_done
//   Sample_cnt  samples sent in the last or current frame
module adc_frame_reader #(
    parameter int          DATA_W    = 10,    // 9..16
    parameter int          FRAME_LEN = 1024,
    parameter int          CNT_W     = 11,    // must hold FRAME_LEN
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Cap_end,
    input  logic              Fifo_empty,
    input  logic [DATA_W-1:0] Fifo_q,
    output logic              Fifo_rdreq,
    output logic [7:0]        Tx_data,
    output logic              Tx_valid,
    input  logic              Tx_ready,
    output logic              Frame_busy,
    output logic              Frame_done,
    output logic              Cap_rearm,
    output logic [CNT_W-1:0]  Sample_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_LATCH,
        ST_HI,
        ST_LO,
        ST_CHK,
        ST_DONE
    } state_t;

    state_t             state_reg;
    logic               cap_end_prev_reg;
    logic [7:0]         checksum_reg;
    logic [7:0]         sample_lo_reg;
    logic [7:0]         tx_data_reg;
    logic               tx_valid_reg;
    logic               frame_busy_reg;
    logic               frame_done_reg;
    logic               cap_rearm_reg;
    logic [CNT_W-1:0]   sample_cnt_reg;

    // Zero-extend to 16 bits so the high byte is {pad, sample[DATA_W-1:8]}
    // for every legal DATA_W without a zero-width replication at DATA_W=16.
    logic [15:0]        fifo_q_ext;
    logic [CNT_W-1:0]   cnt_inc;
    logic               last_sample;
    logic [7:0]         checksum_after_byte;
    logic               start_frame;

    assign fifo_q_ext          = 16'(Fifo_q);
    assign cnt_inc             = sample_cnt_reg + CNT_W'(1);
    assign last_sample         = (cnt_inc == CNT_W'(FRAME_LEN));
    assign checksum_after_byte = checksum_reg ^ tx_data_reg;
    assign start_frame         = Cap_end && !cap_end_prev_reg && !Fifo_empty;

    // The read strobe must coincide with RD and depend on Fifo_empty in that
    // same cycle, so it is decoded from state rather than registered.
    assign Fifo_rdreq = (state_reg == ST_RD) && !Fifo_empty;

    assign Tx_data    = tx_data_reg;
    assign Tx_valid   = tx_valid_reg;
    assign Frame_busy = frame_busy_reg;
    assign Frame_done = frame_done_reg;
    assign Cap_rearm  = cap_rearm_reg;
    assign Sample_cnt = sample_cnt_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg        <= ST_IDLE;
            cap_end_prev_reg <= 1'b0;
            checksum_reg     <= 8'h00;
            sample_lo_reg    <= 8'h00;
            tx_data_reg      <= 8'h00;
            tx_valid_reg     <= 1'b0;
            frame_busy_reg   <= 1'b0;
            frame_done_reg   <= 1'b0;
            cap_rearm_reg    <= 1'b0;
            sample_cnt_reg   <= '0;
        end else begin
            cap_end_prev_reg <= Cap_end;
            frame_done_reg   <= 1'b0;
            cap_rearm_reg    <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    // Only a fresh edge seen while idle starts a frame; a held
                    // level or an edge during a frame never retriggers.
                    if (start_frame) begin
                        state_reg      <= ST_HDR;
                        tx_data_reg    <= HEADER;
                        tx_valid_reg   <= 1'b1;
                        frame_busy_reg <= 1'b1;
                        checksum_reg   <= 8'h00;
                        sample_cnt_reg <= '0;
                    end
                end

                ST_HDR: begin
                    if (Tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_RD;
                    end
                end

                ST_RD: begin
                    // An empty FIFO here ends a short frame early.
                    if (Fifo_empty) begin
                        tx_data_reg  <= checksum_reg;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_CHK;
                    end else begin
                        state_reg <= ST_LATCH;
                    end
                end

                ST_LATCH: begin
                    // Fifo_q is valid now. Only the low byte needs keeping; the
                    // high byte goes straight into the output register.
                    sample_lo_reg <= fifo_q_ext[7:0];
                    tx_data_reg   <= fifo_q_ext[15:8];
                    tx_valid_reg  <= 1'b1;
                    state_reg     <= ST_HI;
                end

                ST_HI: begin
                    if (Tx_ready) begin
                        checksum_reg <= checksum_after_byte;
                        tx_data_reg  <= sample_lo_reg;
                        state_reg    <= ST_LO;
                    end
                end

                ST_LO: begin
                    if (Tx_ready) begin
                        checksum_reg   <= checksum_after_byte;
                        sample_cnt_reg <= cnt_inc;
                        if (last_sample) begin
                            // Valid stays high straight into the checksum byte.
                            tx_data_reg <= checksum_after_byte;
                            state_reg   <= ST_CHK;
                        end else begin
                            tx_valid_reg <= 1'b0;
                            state_reg    <= ST_RD;
                        end
                    end
                end

                ST_CHK: begin
                    if (Tx_ready) begin
                        tx_valid_reg   <= 1'b0;
                        frame_busy_reg <= 1'b0;
                        frame_done_reg <= 1'b1;
                        cap_rearm_reg  <= 1'b1;
                        state_reg      <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
